// File: rtl/riscv_alu_issue.sv
// Decode/issue stage for riscv_alu: decodes one RV32I/M ALU instruction per cycle and
// presents op/A/B through a registered two-entry skid buffer with valid/ready handshakes.
module riscv_alu_issue #(
    parameter bit ENABLE_MUL = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [31:0]      in_rs1_i,
    input  logic [31:0]      in_rs2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       alu_op_o,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    output logic [4:0]       rd_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] issued_cnt_o
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    entry_t         w_dec;
    logic [3:0]     w_f3_op;
    logic           w_legal;
    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic [6:0]     w_funct7;

    entry_t         r_main;
    entry_t         r_skid;
    logic           r_main_valid;
    logic           r_skid_valid;
    logic           r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic           w_acc;
    logic           w_iss;
    logic           w_skid_valid_next;

    assign w_opcode = in_instr_i[6:0];
    assign w_funct3 = in_instr_i[14:12];
    assign w_funct7 = in_instr_i[31:25];

    // funct3 -> op for the funct7=0 / I-type column; SUB/SRA/MUL are patched below
    always_comb begin
        w_f3_op = OP_ADD;
        case (w_funct3)
            3'b000: w_f3_op = OP_ADD;
            3'b001: w_f3_op = OP_SLL;
            3'b010: w_f3_op = OP_SLT;
            3'b011: w_f3_op = OP_SLTU;
            3'b100: w_f3_op = OP_XOR;
            3'b101: w_f3_op = OP_SRL;
            3'b110: w_f3_op = OP_OR;
            3'b111: w_f3_op = OP_AND;
            default: w_f3_op = OP_ADD;
        endcase
    end

    always_comb begin
        w_dec    = '0;
        w_legal  = 1'b0;
        w_dec.rd = in_instr_i[11:7];
        case (w_opcode)
            7'b0110011: begin
                w_dec.a = in_rs1_i;
                w_dec.b = in_rs2_i;
                if (w_funct7 == 7'b0000000) begin
                    w_dec.op = w_f3_op;
                    w_legal  = 1'b1;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_dec.op = OP_SUB;
                    w_legal  = 1'b1;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                    w_dec.op = OP_SRA;
                    w_legal  = 1'b1;
                end else if (w_funct7 == 7'b0000001 && w_funct3 == 3'b000 && ENABLE_MUL) begin
                    w_dec.op = OP_MUL;
                    w_legal  = 1'b1;
                end
            end
            7'b0010011: begin
                w_dec.a  = in_rs1_i;
                w_dec.op = w_f3_op;
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_dec.b = {27'b0, in_instr_i[24:20]};
                    if (w_funct7 == 7'b0000000) begin
                        w_legal = 1'b1;
                    end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                        w_dec.op = OP_SRA;
                        w_legal  = 1'b1;
                    end
                end else begin
                    w_dec.b = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
                    w_legal = 1'b1;
                end
            end
            7'b0110111: begin
                w_dec.op = OP_ADD;
                w_dec.a  = '0;
                w_dec.b  = {in_instr_i[31:12], 12'b0};
                w_legal  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_dec     = '0;
            w_dec.ill = 1'b1;
        end
    end

    assign w_acc = in_valid_i && r_in_ready;
    assign w_iss = r_main_valid && out_ready_i;

    // Skid only holds an entry while main is occupied and stalled
    always_comb begin
        if (!r_main_valid || w_iss) begin
            w_skid_valid_next = 1'b0;
        end else begin
            w_skid_valid_next = r_skid_valid || w_acc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_cnt        <= '0;
        end else begin
            if (!r_main_valid || w_iss) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                end else if (w_acc) begin
                    r_main       <= w_dec;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid <= w_dec;
            end
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= !w_skid_valid_next;
            if (w_iss) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready_o   = r_in_ready;
    assign out_valid_o  = r_main_valid;
    assign alu_op_o     = r_main.op;
    assign alu_a_o      = r_main.a;
    assign alu_b_o      = r_main.b;
    assign rd_o         = r_main.rd;
    assign illegal_o    = r_main.ill;
    assign issued_cnt_o = r_cnt;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Randomized bench for riscv_alu_issue: two instances (MUL enabled / disabled) checked
// against a queue-based reference of the decode rules and the two-entry buffer capacity.
module tb_riscv_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic [31:0] in_instr_i;
    logic [31:0] in_rs1_i;
    logic [31:0] in_rs2_i;
    logic        out_ready_i;

    logic        in_ready_o,  out_valid_o,  illegal_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [4:0]  rd_o;
    logic [3:0]  issued_cnt_o;

    logic        nm_in_ready, nm_out_valid, nm_illegal;
    logic [3:0]  nm_op;
    logic [31:0] nm_a, nm_b;
    logic [4:0]  nm_rd;
    logic [3:0]  nm_cnt;

    always #5 clk_i = ~clk_i;

    riscv_alu_issue #(.ENABLE_MUL(1'b1), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .rd_o(rd_o), .illegal_o(illegal_o), .issued_cnt_o(issued_cnt_o)
    );

    riscv_alu_issue #(.ENABLE_MUL(1'b0), .CNT_W(4)) dut_nomul (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(nm_in_ready),
        .in_instr_i(in_instr_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .out_valid_o(nm_out_valid), .out_ready_i(out_ready_i),
        .alu_op_o(nm_op), .alu_a_o(nm_a), .alu_b_o(nm_b),
        .rd_o(nm_rd), .illegal_o(nm_illegal), .issued_cnt_o(nm_cnt)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q_mul[$];
    exp_t q_nomul[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;   // ADD
            3'd1: return 4'd5;   // SLL
            3'd2: return 4'd8;   // SLT
            3'd3: return 4'd9;   // SLTU
            3'd4: return 4'd4;   // XOR
            3'd5: return 4'd6;   // SRL
            3'd6: return 4'd3;   // OR
            default: return 4'd2; // AND
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                        input logic [31:0] r2, input bit mul_en);
        exp_t e;
        bit ok;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        ok  = 0;
        e.rd = ins[11:7];
        e.ill = 1'b0;
        e.op = 4'd0;
        e.a = 32'd0;
        e.b = 32'd0;
        if (opc == 7'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 7'h00) begin ok = 1; e.op = arith_op(f3); end
            if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.op = 4'd1; end
            if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = 4'd7; end
            if (f7 == 7'h01 && f3 == 3'd0 && mul_en) begin ok = 1; e.op = 4'd10; end
        end else if (opc == 7'h13) begin
            e.a  = r1;
            e.op = arith_op(f3);
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(ins[24:20]);
                ok  = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'd7;
            end else begin
                e.b = 32'($signed(ins[31:20]));
                ok  = 1;
            end
        end else if (opc == 7'h37) begin
            ok = 1;
            e.op = 4'd0;
            e.a = 32'd0;
            e.b = ins & 32'hFFFF_F000;
        end
        if (!ok) begin
            e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.rd = 5'd0; e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4:    w[6:0] = 7'h37;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_outputs();
        exp_t em, en;
        chk("out_valid", 32'(out_valid_o), 32'(q_mul.size() > 0));
        chk("in_ready", 32'(in_ready_o), 32'(q_mul.size() < 2));
        chk("count", 32'(issued_cnt_o), 32'(model_cnt % 16));
        chk("nm_out_valid", 32'(nm_out_valid), 32'(q_nomul.size() > 0));
        if (out_valid_o && q_mul.size() > 0) begin
            em = q_mul[0];
            chk("op", 32'(alu_op_o), 32'(em.op));
            chk("a", alu_a_o, em.a);
            chk("b", alu_b_o, em.b);
            chk("rd", 32'(rd_o), 32'(em.rd));
            chk("illegal", 32'(illegal_o), 32'(em.ill));
        end
        if (nm_out_valid && q_nomul.size() > 0) begin
            en = q_nomul[0];
            chk("nm_op", 32'(nm_op), 32'(en.op));
            chk("nm_a", nm_a, en.a);
            chk("nm_b", nm_b, en.b);
            chk("nm_rd", 32'(nm_rd), 32'(en.rd));
            chk("nm_illegal", 32'(nm_illegal), 32'(en.ill));
        end
    endtask

    // Called at a falling edge; applies one cycle of stimulus and checks the result.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic rdy, output bit acc);
        bit iss;
        in_valid_i  = v;
        in_instr_i  = ins;
        in_rs1_i    = r1;
        in_rs2_i    = r2;
        out_ready_i = rdy;
        acc = v && in_ready_o;
        iss = out_valid_o && rdy;
        @(posedge clk_i);
        if (iss && q_mul.size() > 0) begin
            void'(q_mul.pop_front());
            void'(q_nomul.pop_front());
        end
        if (iss) model_cnt++;
        if (acc) begin
            q_mul.push_back(ref_decode(ins, r1, r2, 1'b1));
            q_nomul.push_back(ref_decode(ins, r1, r2, 1'b0));
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_count", 32'(issued_cnt_o), 32'd0);
        chk("rst_op", 32'(alu_op_o), 32'd0);
        chk("rst_a", alu_a_o, 32'd0);
        chk("rst_b", alu_b_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        q_mul.delete();
        q_nomul.delete();
        model_cnt = 0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        bit acc;
        int tries;
        logic [31:0] dir[6];
        dir[0] = 32'h002081B3; // ADD
        dir[1] = 32'h402081B3; // SUB
        dir[2] = 32'hFFF00093; // ADDI -1
        dir[3] = 32'h40335293; // SRAI
        dir[4] = 32'h022081B3; // MUL
        dir[5] = 32'h0220C1B3; // DIV

        rst_i = 1'b1;
        in_valid_i = 1'b0; in_instr_i = '0; in_rs1_i = '0; in_rs2_i = '0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        do_reset();

        // Directed decode vectors at full throughput
        for (int i = 0; i < 6; i++) step(1'b1, dir[i], 32'd5, 32'd7, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);

        // Stall with three words offered: first held, second in skid, third back-pressured
        step(1'b1, 32'h00A00513, 32'd1, 32'd0, 1'b0, acc);
        step(1'b1, 32'h00B00593, 32'd2, 32'd0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00C00613, 32'd3, 32'd0, 1'b0, acc);
        chk("stall_in_ready", 32'(in_ready_o), 32'd0);
        tries = 0;
        do begin
            step(1'b1, 32'h00C00613, 32'd3, 32'd0, 1'b1, acc);
            tries++;
        end while (!acc && tries < 10);
        chk("third_accepted", 32'(acc), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);

        // Counter wrap with CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, rand_instr(), $urandom, $urandom, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
        chk("wrap17", 32'(issued_cnt_o), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                 $urandom_range(0, 9) < 7, acc);
        end

        // Reset while both entries are held
        for (int i = 0; i < 3; i++) step(1'b1, rand_instr(), $urandom, $urandom, 1'b0, acc);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
